// File: rtl/chebyshev_recurrence.sv
// Streams Chebyshev terms T_0..T_N of one fixed-point x via T_n = 2*x*T_(n-1) - T_(n-2).
// Define CHEB_SAT_EN to saturate each term instead of wrapping it to WL bits.
module chebyshev_recurrence #(
  parameter int WL = 16,
  parameter int FL = 14,
  parameter int OW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_x,
  input  logic [OW-1:0] in_order,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_t,
  output logic [OW-1:0] out_idx,
  output logic          out_last
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic signed [WL-1:0] T_ONE = {{(WL-FL-1){1'b0}}, 1'b1, {FL{1'b0}}};

  state_t state, state_nx;

  logic signed [WL-1:0]   x_r;
  logic signed [WL-1:0]   t_cur;
  logic signed [WL-1:0]   t_prev;
  logic        [OW-1:0]   order_r;
  logic        [OW-1:0]   idx_r;

  logic signed [2*WL-1:0] prod;
  logic signed [WL+1:0]   s_w;
  logic signed [WL+1:0]   d;
  logic signed [WL-1:0]   t_red;
  logic signed [WL-1:0]   t_next;
  logic                   accept;
  logic                   handshake;
  logic                   is_last;

  // The >>> (FL-1) is folded into the slice; only WL+2 bits of 2*x*T feed the subtract.
  assign prod = x_r * t_cur;
  assign s_w  = prod[WL+FL:FL-1];
  assign d    = s_w - {{2{t_prev[WL-1]}}, t_prev};

`ifdef CHEB_SAT_EN
  localparam logic signed [WL+1:0] D_MAX = {3'b000, {(WL-1){1'b1}}};
  localparam logic signed [WL+1:0] D_MIN = {3'b111, {(WL-1){1'b0}}};

  logic prod_unused;
  assign prod_unused = ^{prod[FL-2:0], prod[2*WL-1:WL+FL+1]};

  always_comb begin
    t_red = d[WL-1:0];
    if (d > D_MAX)
      t_red = {1'b0, {(WL-1){1'b1}}};
    else if (d < D_MIN)
      t_red = {1'b1, {(WL-1){1'b0}}};
  end
`else
  logic prod_unused;
  assign prod_unused = ^{prod[FL-2:0], prod[2*WL-1:WL+FL+1], d[WL+1:WL]};
  assign t_red       = d[WL-1:0];
`endif

  assign t_next    = (idx_r == '0) ? x_r : t_red;
  assign is_last   = (idx_r == order_r);
  assign accept    = (state == IDLE) && in_valid;
  assign handshake = (state == EMIT) && out_ready;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = is_last;
        if (out_ready && is_last)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      x_r     <= '0;
      t_cur   <= '0;
      t_prev  <= '0;
      order_r <= '0;
      idx_r   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        x_r     <= in_x;
        order_r <= in_order;
        t_cur   <= T_ONE;
        t_prev  <= '0;
        idx_r   <= '0;
      end else if (handshake && !is_last) begin
        t_prev <= t_cur;
        t_cur  <= t_next;
        idx_r  <= idx_r + OW'(1);
      end
    end
  end

  assign out_t   = t_cur;
  assign out_idx = idx_r;

endmodule

// File: tb/tb_chebyshev_recurrence.sv
// Self-checking bench for chebyshev_recurrence: directed cases plus random x/order/backpressure.
module tb_chebyshev_recurrence;

  localparam int WL = 16;
  localparam int FL = 14;
  localparam int OW = 4;
  localparam int BUDGET = 300;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_x;
  logic [OW-1:0] in_order;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_t;
  logic [OW-1:0] out_idx;
  logic          out_last;

  int checks   = 0;
  int failures = 0;

  longint exp_t [0:15];
  longint obs_t [0:15];

  chebyshev_recurrence #(.WL(WL), .FL(FL), .OW(OW)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_order (in_order),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_t    (out_t),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= (m >>> 1)) r -= m;
    return r;
  endfunction

  // Reference terms from the recurrence with plain integer arithmetic.
  function automatic void build_model(input longint x, input int order);
    longint s, d, hi, lo;
    hi = (longint'(1) << (WL-1)) - 1;
    lo = -(longint'(1) << (WL-1));
    exp_t[0] = longint'(1) << FL;
    exp_t[1] = x;
    for (int n = 2; n <= order; n++) begin
      s = (x * exp_t[n-1]) >>> (FL-1);
      d = wrap(s - exp_t[n-2], WL+2);
`ifdef CHEB_SAT_EN
      exp_t[n] = (d > hi) ? hi : (d < lo) ? lo : d;
`else
      exp_t[n] = wrap(d, WL);
`endif
    end
  endfunction

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_seq(input longint x, input int order, input int mode,
                         input bit inject, input int rst_at);
    int n, cyc;
    build_model(x, order);
    @(negedge clock);
    check("idle_ready", in_ready, 1);
    check("idle_valid", out_valid, 0);
    in_valid = 1'b1;
    in_x     = WL'(x);
    in_order = OW'(order);
    @(negedge clock);
    in_valid = 1'b0;
    n = 0;
    cyc = 0;
    while (n <= order && cyc < BUDGET) begin
      if (inject && cyc == 0) begin
        in_valid = 1'b1;
        in_x     = WL'($urandom);
        in_order = OW'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      check("busy_ready", in_ready, 0);
      check("out_valid", out_valid, 1);
      check($sformatf("t[%0d]", n), longint'($signed(out_t)), exp_t[n]);
      check("idx", out_idx, n);
      check("last", out_last, (n == order) ? 1 : 0);
      obs_t[n] = longint'($signed(out_t));
      if (n == rst_at) begin
        reset     = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_t", out_t, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_ready) n++;
      @(negedge clock);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("terms_seen", n, order + 1);
    if (mode == 0) check("throughput", cyc, order + 1);
    check("done_valid", out_valid, 0);
    check("done_ready", in_ready, 1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_order  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_ready", in_ready, 1);
    check("reset_valid", out_valid, 0);
    check("reset_t", out_t, 0);
    check("reset_idx", out_idx, 0);
    check("reset_last", out_last, 0);
    reset = 1'b0;

    run_seq(8192, 3, 0, 1'b0, -1);
    check("half_t0", obs_t[0], 16384);
    check("half_t1", obs_t[1], 8192);
    check("half_t2", obs_t[2], -8192);
    check("half_t3", obs_t[3], -16384);

    run_seq(16384, 5, 0, 1'b0, -1);
    check("one_t5", obs_t[5], 16384);

    run_seq(20480, 2, 0, 1'b0, -1);
`ifdef CHEB_SAT_EN
    check("big_t2", obs_t[2], 32767);
`else
    check("big_t2", obs_t[2], -30720);
`endif

    run_seq(-5000, 0, 0, 1'b0, -1);
    check("ord0_t0", obs_t[0], 16384);

    run_seq(-16384, 4, 1, 1'b1, -1);
    check("neg_t3", obs_t[3], -16384);
    check("neg_t4", obs_t[4], 16384);

    run_seq(12345, 7, 0, 1'b0, 2);
    run_seq(-3000, 3, 0, 1'b0, -1);

    for (int i = 0; i < 12; i++) begin
      longint rx;
      rx = longint'($signed(WL'($urandom)));
      run_seq(rx, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
